morse_stream_tx: RTL and testbench

// - Parametrised Morse transmitter for the full A-Z alphabet plus a word-space code.
// - Letters are queued through a valid/ready FIFO and sent back-to-back with standard ITU timing:
//   dot = 1 unit, dash = 3 units, element gap = 1 unit, letter gap = 3 units, word gap = 7 units.
// - Drives a single on/off line plus a per-unit strobe. Sits between the keypad/letter-select logic
//   and the LED/buzzer output stage.

---
 rtl/morse_stream_tx.sv | 175 +++++++++++++++++
 tb/tb_morse_stream_tx.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/morse_stream_tx.sv
// rtl/morse_stream_tx.sv - queued A-Z Morse transmitter with ITU unit timing
module morse_stream_tx #(
    parameter int CLOCK_FREQUENCY = 500,
    parameter int UNIT_RATE       = 2,
    parameter int FIFO_DEPTH      = 4
) (
    input  logic                                 ClockIn,
    input  logic                                 Reset,
    input  logic                                 LetterValid,
    input  logic [4:0]                           Letter,
    output logic                                 LetterReady,
    input  logic                                 Abort,
    output logic                                 DotDashOut,
    output logic                                 NewBitOut,
    output logic                                 Busy,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]      FifoCount
);
    localparam int DIV = CLOCK_FREQUENCY / UNIT_RATE;
    localparam int DW  = $clog2(DIV);
    localparam int AW  = $clog2(FIFO_DEPTH);
    localparam int CW  = $clog2(FIFO_DEPTH + 1);
    localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);

    typedef enum logic [2:0] {IDLE, LOAD, MARK, SPACE, LGAP, WGAP} state_t;

    state_t          state, state_d;
    logic [4:0]      mem [FIFO_DEPTH];
    logic [AW-1:0]   wr_ptr, rd_ptr;
    logic [CW-1:0]   count, count_d;
    logic            ready_q;
    logic            push, pop;
    logic [4:0]      head;
    logic [6:0]      rom_entry;
    logic [DW-1:0]   div_cnt;
    logic            tick, timed;
    logic [2:0]      units, units_d;
    logic [3:0]      shift, shift_d;
    logic [2:0]      elems, elems_d;
    logic            new_bit_d;
    logic            dd_q, nb_q;

    // {length, pattern}: pattern is left-aligned, MSB first, 1 = dash
    function automatic logic [6:0] rom(input logic [4:0] c);
        case (c)
            5'd0:  rom = {3'd2, 4'b0100}; 5'd1:  rom = {3'd4, 4'b1000};
            5'd2:  rom = {3'd4, 4'b1010}; 5'd3:  rom = {3'd3, 4'b1000};
            5'd4:  rom = {3'd1, 4'b0000}; 5'd5:  rom = {3'd4, 4'b0010};
            5'd6:  rom = {3'd3, 4'b1100}; 5'd7:  rom = {3'd4, 4'b0000};
            5'd8:  rom = {3'd2, 4'b0000}; 5'd9:  rom = {3'd4, 4'b0111};
            5'd10: rom = {3'd3, 4'b1010}; 5'd11: rom = {3'd4, 4'b0100};
            5'd12: rom = {3'd2, 4'b1100}; 5'd13: rom = {3'd2, 4'b1000};
            5'd14: rom = {3'd3, 4'b1110}; 5'd15: rom = {3'd4, 4'b0110};
            5'd16: rom = {3'd4, 4'b1101}; 5'd17: rom = {3'd3, 4'b0100};
            5'd18: rom = {3'd3, 4'b0000}; 5'd19: rom = {3'd1, 4'b1000};
            5'd20: rom = {3'd3, 4'b0010}; 5'd21: rom = {3'd4, 4'b0001};
            5'd22: rom = {3'd3, 4'b0110}; 5'd23: rom = {3'd4, 4'b1001};
            5'd24: rom = {3'd4, 4'b1011}; 5'd25: rom = {3'd4, 4'b1100};
            default: rom = 7'd0;
        endcase
    endfunction

    assign push      = LetterValid & ready_q & ~Abort;
    assign pop       = (state == LOAD);
    assign head      = mem[rd_ptr];
    assign rom_entry = rom(head);
    assign timed     = (state == MARK) || (state == SPACE) || (state == LGAP) || (state == WGAP);
    assign tick      = timed && (div_cnt == '0);

    // Queue occupancy after this edge's push/pop
    always_comb begin
        count_d = count;
        case ({push, pop})
            2'b10:   count_d = count + CW'(1);
            2'b01:   count_d = count - CW'(1);
            default: count_d = count;
        endcase
    end

    // Letter storage; contents are only meaningful between the pointers
    always_ff @(posedge ClockIn) begin
        if (push) mem[wr_ptr] <= Letter;
    end

    // Queue pointers, count and registered ready
    always_ff @(posedge ClockIn or negedge Reset) begin
        if (!Reset) begin
            wr_ptr <= '0; rd_ptr <= '0; count <= '0; ready_q <= 1'b1;
        end else if (Abort) begin
            wr_ptr <= '0; rd_ptr <= '0; count <= '0; ready_q <= 1'b1;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            count   <= count_d;
            ready_q <= (count_d != CW'(FIFO_DEPTH));
        end
    end

    // Unit divider, parked at DIV-1 whenever no unit is being timed
    always_ff @(posedge ClockIn or negedge Reset) begin
        if (!Reset)                   div_cnt <= DIV_LAST;
        else if (Abort || !timed || tick) div_cnt <= DIV_LAST;
        else                          div_cnt <= div_cnt - DW'(1);
    end

    // Next-state, unit and element bookkeeping
    always_comb begin
        state_d = state;
        units_d = units;
        shift_d = shift;
        elems_d = elems;
        case (state)
            IDLE: if (count != '0) state_d = LOAD;
            LOAD: begin
                if (head < 5'd26) begin
                    state_d = MARK;
                    shift_d = rom_entry[3:0];
                    elems_d = rom_entry[6:4];
                    units_d = rom_entry[3] ? 3'd3 : 3'd1;
                end else if (head == 5'd26) begin
                    state_d = WGAP;
                    units_d = 3'd4;
                end else begin
                    state_d = (count > CW'(1)) ? LOAD : IDLE;
                end
            end
            MARK: if (tick) begin
                if (units > 3'd1) begin
                    units_d = units - 3'd1;
                end else if (elems > 3'd1) begin
                    state_d = SPACE;
                    units_d = 3'd1;
                    shift_d = {shift[2:0], 1'b0};
                    elems_d = elems - 3'd1;
                end else begin
                    state_d = LGAP;
                    units_d = 3'd3;
                end
            end
            SPACE: if (tick) begin
                state_d = MARK;
                units_d = shift[3] ? 3'd3 : 3'd1;
            end
            LGAP, WGAP: if (tick) begin
                if (units > 3'd1) units_d = units - 3'd1;
                else              state_d = (count != '0) ? LOAD : IDLE;
            end
            default: state_d = IDLE;
        endcase
        new_bit_d = ((state_d == MARK) || (state_d == SPACE) || (state_d == LGAP) || (state_d == WGAP))
                    && (tick || (state == LOAD));
    end

    // State register and registered line/strobe outputs
    always_ff @(posedge ClockIn or negedge Reset) begin
        if (!Reset) begin
            state <= IDLE; units <= '0; shift <= '0; elems <= '0; dd_q <= 1'b0; nb_q <= 1'b0;
        end else if (Abort) begin
            state <= IDLE; units <= '0; shift <= '0; elems <= '0; dd_q <= 1'b0; nb_q <= 1'b0;
        end else begin
            state <= state_d;
            units <= units_d;
            shift <= shift_d;
            elems <= elems_d;
            dd_q  <= (state_d == MARK);
            nb_q  <= new_bit_d;
        end
    end

    assign LetterReady = ready_q;
    assign DotDashOut  = dd_q;
    assign NewBitOut   = nb_q;
    assign FifoCount   = count;
    assign Busy        = (state != IDLE) || (count != '0);

endmodule

// File: tb/tb_morse_stream_tx.sv
// tb/tb_morse_stream_tx.sv - table, sequence and random-model checks for morse_stream_tx
module tb_morse_stream_tx;
    localparam int DIV = 4;
    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       lv = 1'b0;
    logic [4:0] letter = 5'd0;
    logic       abort = 1'b0;
    logic       ready, dd, nb, busy;
    logic [2:0] fcount;

    int checks = 0;
    int errors = 0;

    morse_stream_tx #(.CLOCK_FREQUENCY(8), .UNIT_RATE(2), .FIFO_DEPTH(DEPTH)) dut (
        .ClockIn(clk), .Reset(rst_n), .LetterValid(lv), .Letter(letter), .LetterReady(ready),
        .Abort(abort), .DotDashOut(dd), .NewBitOut(nb), .Busy(busy), .FifoCount(fcount)
    );

    always #5 clk = ~clk;

    string morse [26] = '{".-", "-...", "-.-.", "-..", ".", "..-.", "--.", "....", "..", ".---",
                          "-.-", ".-..", "--", "-.", "---", ".--.", "--.-", ".-.", "...", "-",
                          "..-", "...-", ".--", "-..-", "-.--", "--.."};

    typedef struct {
        logic [4:0] code;
        int high;
        int pulses;
        int busy_n;
        int first;
    } vec_t;
    vec_t vecs [9];

    int line_q[$];
    int on_runs[$];
    int off_runs[$];

    // reference model state
    int  mq[$];
    bit  w_dd[$];
    bit  w_nb[$];
    bit  m_pend, m_active, m_dd, m_nb, m_ready;
    int  m_count;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle();
        for (int k = 0; k < 300; k++) begin
            if (!busy) break;
            tick();
        end
        check("wait_idle", busy, 0);
    endtask

    task automatic finish_record();
        for (int k = 0; k < 500; k++) begin
            if (!busy) break;
            tick();
            if (busy) line_q.push_back(int'(dd));
        end
        check("record_done", busy, 0);
    endtask

    function automatic void make_runs();
        int i;
        int n;
        on_runs.delete();
        off_runs.delete();
        i = 0;
        while (i < line_q.size() && line_q[i] == 0) i++;
        while (i < line_q.size()) begin
            n = 0;
            while (i < line_q.size() && line_q[i] == 1) begin n++; i++; end
            on_runs.push_back(n);
            n = 0;
            while (i < line_q.size() && line_q[i] == 0) begin n++; i++; end
            if (n > 0) off_runs.push_back(n);
        end
    endfunction

    function automatic void add_units(input bit mark, input int n);
        for (int u = 0; u < n; u++)
            for (int c = 0; c < DIV; c++) begin
                w_dd.push_back(mark);
                w_nb.push_back(c == 0);
            end
    endfunction

    function automatic void expand(input int code);
        string s;
        if (code == 26) begin
            add_units(1'b0, 4);
        end else if (code < 26) begin
            s = morse[code];
            for (int e = 0; e < s.len(); e++) begin
                add_units(1'b1, (s[e] == "-") ? 3 : 1);
                add_units(1'b0, (e == s.len() - 1) ? 3 : 1);
            end
        end
    endfunction

    function automatic void model_reset();
        mq.delete(); w_dd.delete(); w_nb.delete();
        m_pend = 0; m_active = 0; m_dd = 0; m_nb = 0; m_count = 0; m_ready = 1;
    endfunction

    // one clock edge of the reference, using the inputs present before the edge
    function automatic void model_step(input bit v, input int code, input bit ab);
        bit acc;
        acc = v && m_ready && !ab;
        if (ab) begin
            model_reset();
            return;
        end
        m_pend = 0;
        if (w_dd.size() > 0) begin
            m_dd = w_dd.pop_front();
            m_nb = w_nb.pop_front();
            m_active = 1;
        end else if (mq.size() > 0) begin
            expand(mq.pop_front());
            m_pend = 1;
            m_dd = 0; m_nb = 0; m_active = 1;
        end else begin
            m_dd = 0; m_nb = 0; m_active = 0;
        end
        if (acc) mq.push_back(code);
        m_count = mq.size() + int'(m_pend);
        m_ready = (m_count < DEPTH);
    endfunction

    task automatic push_and_abort(input bit use_reset);
        lv = 1; letter = 5'd1; tick();
        letter = 5'd2; tick();
        lv = 0;
        for (int k = 0; k < 20; k++) begin
            if (dd) break;
            tick();
        end
        check(use_reset ? "rst_dash_seen" : "abort_dash_seen", dd, 1);
        tick(); tick();
        if (use_reset) begin
            #3 rst_n = 0;
            #1;
        end else begin
            abort = 1;
            tick();
            abort = 0;
        end
        check(use_reset ? "rst_dd" : "abort_dd", dd, 0);
        check(use_reset ? "rst_nb" : "abort_nb", nb, 0);
        check(use_reset ? "rst_count" : "abort_count", fcount, 0);
        check(use_reset ? "rst_busy" : "abort_busy", busy, 0);
        check(use_reset ? "rst_ready" : "abort_ready", ready, 1);
        if (use_reset) begin
            tick();
            rst_n = 1;
        end
        for (int k = 0; k < 6; k++) begin
            tick();
            check(use_reset ? "rst_stays_off" : "abort_stays_off", dd | busy, 0);
        end
    endtask

    initial begin
        int high, pulses, busy_n, first, acc, sixth, maxc, saw_nr;
        bit rdy, v, ab;
        int code;

        vecs[0] = '{5'd4,  4,  4, 18,  2};
        vecs[1] = '{5'd0,  16, 8, 34,  2};
        vecs[2] = '{5'd19, 12, 6, 26,  2};
        vecs[3] = '{5'd1,  24, 12, 50, 2};
        vecs[4] = '{5'd18, 12, 8, 34,  2};
        vecs[5] = '{5'd14, 36, 14, 58, 2};
        vecs[6] = '{5'd25, 32, 14, 58, 2};
        vecs[7] = '{5'd26, 0,  4, 18, -1};
        vecs[8] = '{5'd30, 0,  0,  2, -1};

        // reset held with random inputs
        for (int k = 0; k < 6; k++) begin
            lv = 1'($urandom); letter = 5'($urandom); abort = 1'($urandom);
            tick();
            check("rst_dd", dd, 0);
            check("rst_nb", nb, 0);
            check("rst_busy", busy, 0);
            check("rst_count", fcount, 0);
            check("rst_ready", ready, 1);
        end
        lv = 0; abort = 0;
        rst_n = 1;
        for (int k = 0; k < 4; k++) begin
            tick();
            check("post_rst_idle", busy | dd | nb, 0);
        end

        // single letters from idle
        for (int i = 0; i < 9; i++) begin
            wait_idle();
            lv = 1; letter = vecs[i].code;
            tick();
            lv = 0;
            high = 0; pulses = 0; busy_n = 0; first = -1;
            for (int k = 0; k < 300; k++) begin
                if (!busy) break;
                busy_n++;
                high += int'(dd);
                pulses += int'(nb);
                if (dd && first < 0) first = k;
                tick();
            end
            check($sformatf("vec%0d_high", i), high, vecs[i].high);
            check($sformatf("vec%0d_pulses", i), pulses, vecs[i].pulses);
            check($sformatf("vec%0d_busy", i), busy_n, vecs[i].busy_n);
            check($sformatf("vec%0d_first", i), first, vecs[i].first);
        end

        // six T's back to back: queue fills, sixth held until a pop
        wait_idle();
        line_q.delete();
        acc = 0; sixth = -1; maxc = 0; saw_nr = 0;
        lv = 1; letter = 5'd19;
        for (int c = 0; c < 100 && acc < 6; c++) begin
            rdy = ready;
            tick();
            if (rdy) begin
                acc++;
                if (acc == 6) begin sixth = c; lv = 0; end
            end
            if (int'(fcount) > maxc) maxc = int'(fcount);
            if (!ready) saw_nr = 1;
            line_q.push_back(int'(dd));
        end
        lv = 0;
        finish_record();
        make_runs();
        check("t6_accepted", acc, 6);
        check("t6_sixth_edge", sixth, 28);
        check("t6_max_count", maxc, 4);
        check("t6_not_ready_seen", saw_nr, 1);
        check("t6_marks", on_runs.size(), 6);
        check("t6_gaps", off_runs.size(), 6);
        for (int k = 0; k < on_runs.size(); k++) check("t6_mark_len", on_runs[k], 12);
        for (int k = 0; k < off_runs.size(); k++) check("t6_gap_len", off_runs[k], (k < 5) ? 13 : 12);

        // E, word space, E: letter gap + LOAD + word gap + LOAD between the marks
        wait_idle();
        line_q.delete();
        lv = 1; letter = 5'd4;  tick(); line_q.push_back(int'(dd));
        letter = 5'd26;         tick(); line_q.push_back(int'(dd));
        letter = 5'd4;          tick(); line_q.push_back(int'(dd));
        lv = 0;
        finish_record();
        make_runs();
        check("ewe_marks", on_runs.size(), 2);
        check("ewe_offs", off_runs.size(), 2);
        if (on_runs.size() == 2 && off_runs.size() == 2) begin
            check("ewe_mark0", on_runs[0], 4);
            check("ewe_word_gap", off_runs[0], 30);
            check("ewe_mark1", on_runs[1], 4);
            check("ewe_tail", off_runs[1], 12);
        end

        // abort and async reset during B's first dash
        wait_idle();
        push_and_abort(1'b0);
        push_and_abort(1'b1);

        // randomized traffic against the reference model
        model_reset();
        for (int c = 0; c < 4000; c++) begin
            v = ((c / 500) % 2 == 0) ? ($urandom_range(1, 2) == 1) : ($urandom_range(1, 40) == 1);
            case ($urandom_range(0, 9))
                8:       code = 26;
                9:       code = $urandom_range(27, 31);
                default: code = $urandom_range(0, 25);
            endcase
            ab = ($urandom_range(1, 300) == 1);
            lv = v; letter = 5'(code); abort = ab;
            @(posedge clk);
            model_step(v, code, ab);
            #1;
            check("rnd_dd", dd, m_dd);
            check("rnd_nb", nb, m_nb);
            check("rnd_busy", busy, m_active || (m_count != 0));
            check("rnd_count", fcount, m_count);
            check("rnd_ready", ready, m_ready);
        end
        lv = 0; abort = 0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
